// File: rtl/float_to_double.sv
// float_to_double
//   Converts an IEEE-754 single-precision operand to double precision using
//   a valid/ack handshake on both sides. Normal, zero, infinity and NaN
//   inputs convert in one cycle. Subnormal inputs are normalised one bit per
//   cycle; every single-precision subnormal is a normal double, so the result
//   is always exact.
//
// Ports
//   clk           system clock, all state changes on the rising edge
//   rst           synchronous active-high reset
//   input_a       single-precision operand
//   input_a_stb   upstream: input_a is valid
//   input_a_ack   registered; high only while waiting for an operand
//   output_z      double-precision result, registered, holds after transfer
//   output_z_stb  registered; high while output_z holds a fresh result
//   output_z_ack  downstream: output_z accepted
//
// State table
//   GET_A     | waiting for an operand, input_a_ack high
//   CONVERT   | split fields, finish directly or load subnormal mantissa
//   NORMALISE | shift subnormal mantissa until the hidden bit is at bit 23
//   PUT_Z     | result presented, waiting for output_z_ack

module float_to_double (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] input_a,
    input  logic        input_a_stb,
    output logic        input_a_ack,
    output logic [63:0] output_z,
    output logic        output_z_stb,
    input  logic        output_z_ack
);

    typedef enum logic [1:0] {
        GET_A,
        CONVERT,
        NORMALISE,
        PUT_Z
    } state_t;

    state_t             state;
    logic [31:0]        a;
    logic [23:0]        m;
    // Unbiased exponent during normalisation: ranges -126 down to -149.
    logic signed [11:0] x;

    logic [7:0]         exp_a;
    logic [22:0]        frac_a;

    assign exp_a  = a[30:23];
    assign frac_a = a[22:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= GET_A;
            input_a_ack  <= 1'b0;
            output_z_stb <= 1'b0;
        end else begin
            case (state)
                GET_A: begin
                    if (input_a_ack && input_a_stb) begin
                        a           <= input_a;
                        input_a_ack <= 1'b0;
                        state       <= CONVERT;
                    end else begin
                        // Ack rises one edge after entering GET_A, so no
                        // operand can be taken on the same edge as a transfer.
                        input_a_ack <= 1'b1;
                    end
                end

                CONVERT: begin
                    output_z[63] <= a[31];
                    if (exp_a == 8'd255) begin
                        output_z[62:52] <= 11'h7FF;
                        output_z[51:0]  <= {frac_a, 29'b0};
                        output_z_stb    <= 1'b1;
                        state           <= PUT_Z;
                    end else if (exp_a == 8'd0) begin
                        if (frac_a == 23'd0) begin
                            output_z[62:0] <= '0;
                            output_z_stb   <= 1'b1;
                            state          <= PUT_Z;
                        end else begin
                            m     <= {1'b0, frac_a};
                            x     <= -12'sd126;
                            state <= NORMALISE;
                        end
                    end else begin
                        // Rebias 127 -> 1023.
                        output_z[62:52] <= {3'b000, exp_a} + 11'd896;
                        output_z[51:0]  <= {frac_a, 29'b0};
                        output_z_stb    <= 1'b1;
                        state           <= PUT_Z;
                    end
                end

                NORMALISE: begin
                    if (m[23]) begin
                        output_z[62:52] <= 11'(x + 12'sd1023);
                        output_z[51:0]  <= {m[22:0], 29'b0};
                        output_z_stb    <= 1'b1;
                        state           <= PUT_Z;
                    end else begin
                        m <= {m[22:0], 1'b0};
                        x <= x - 12'sd1;
                    end
                end

                PUT_Z: begin
                    if (output_z_ack) begin
                        output_z_stb <= 1'b0;
                        state        <= GET_A;
                    end
                end

                default: begin
                    state <= GET_A;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_float_to_double.sv
// Directed and random checks for float_to_double. Inputs are driven #1 after
// a rising edge, outputs sampled #1 after a rising edge.

module tb_float_to_double;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] input_a;
    logic        input_a_stb;
    logic        input_a_ack;
    logic [63:0] output_z;
    logic        output_z_stb;
    logic        output_z_ack;

    int checks = 0;
    int errors = 0;

    float_to_double dut (
        .clk          (clk),
        .rst          (rst),
        .input_a      (input_a),
        .input_a_stb  (input_a_stb),
        .input_a_ack  (input_a_ack),
        .output_z     (output_z),
        .output_z_stb (output_z_stb),
        .output_z_ack (output_z_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Independent reference: locate the leading one of a subnormal fraction
    // and place the exponent directly rather than stepping.
    function automatic logic [63:0] ref_f2d(input logic [31:0] v);
        logic        s;
        logic [7:0]  e;
        logic [22:0] f;
        logic [22:0] mant;
        int          p;
        s = v[31];
        e = v[30:23];
        f = v[22:0];
        if (e == 8'hFF) return {s, 11'h7FF, f, 29'b0};
        if (e == 8'h00 && f == 23'd0) return {s, 63'b0};
        if (e == 8'h00) begin
            p = 0;
            for (int i = 0; i < 23; i++) if (f[i]) p = i;
            mant = f << (23 - p);
            return {s, 11'(p + 874), mant, 29'b0};
        end
        return {s, 11'(int'(e) + 896), f, 29'b0};
    endfunction

    function automatic int ref_lat(input logic [31:0] v);
        int p;
        if (v[30:23] != 8'h00 || v[22:0] == 23'd0) return 1;
        p = 0;
        for (int i = 0; i < 23; i++) if (v[i]) p = i;
        return 25 - p;
    endfunction

    // Offer one operand; the accepting edge is E0.
    task automatic send(input logic [31:0] v);
        int n;
        n = 0;
        while (!input_a_ack && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        chk("ack_timeout", 64'(n < 60), 64'd1);
        input_a     = v;
        input_a_stb = 1'b1;
        @(posedge clk); #1;
        input_a_stb = 1'b0;
        chk("ack_drop", 64'(input_a_ack), 64'd0);
    endtask

    // Count edges after E0 until output_z_stb, check latency and value.
    task automatic get(input string tag, input logic [63:0] exp_z, input int exp_lat, input int gap);
        int n;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!output_z_stb && n < 60);
        chk({tag, "_lat"}, 64'(n), 64'(exp_lat));
        chk({tag, "_z"}, output_z, exp_z);
        for (int i = 0; i < gap; i++) begin
            @(posedge clk); #1;
            chk({tag, "_hold_stb"}, 64'(output_z_stb), 64'd1);
            chk({tag, "_hold_z"}, output_z, exp_z);
        end
        output_z_ack = 1'b1;
        @(posedge clk); #1;
        output_z_ack = 1'b0;
        chk({tag, "_stb_drop"}, 64'(output_z_stb), 64'd0);
    endtask

    initial begin
        logic [31:0] v;
        int          n;
        logic        seen;

        rst          = 1'b1;
        input_a      = '0;
        input_a_stb  = 1'b0;
        output_z_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack", 64'(input_a_ack), 64'd0);
        chk("rst_stb", 64'(output_z_stb), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("ack_after_rst", 64'(input_a_ack), 64'd1);

        send(32'h3F800000); get("one",     64'h3FF0000000000000, 1, 0);
        send(32'hC0200000); get("m2p5",    64'hC004000000000000, 1, 0);
        send(32'h80000000); get("negzero", 64'h8000000000000000, 1, 0);
        send(32'h00000000); get("zero",    64'h0000000000000000, 1, 0);
        send(32'h7F800000); get("inf",     64'h7FF0000000000000, 1, 0);
        send(32'h7FC00000); get("qnan",    64'h7FF8000000000000, 1, 0);
        send(32'hFF800001); get("snan",    64'hFFF0000020000000, 1, 0);
        send(32'h00000001); get("sub_min", 64'h36A0000000000000, 25, 0);
        send(32'h00400000); get("sub_max", 64'h3800000000000000, 3, 0);
        send(32'h807FFFFF); get("sub_neg", 64'hB80FFFFFC0000000, 3, 0);
        send(32'h7F7FFFFF); get("maxnorm", 64'h47EFFFFFE0000000, 1, 0);
        send(32'h00800000); get("minnorm", 64'h3810000000000000, 1, 0);

        // Backpressure: stale strobes on both sides must be ignored.
        send(32'h40490FDB);
        n = 0;
        while (!output_z_stb && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        input_a     = 32'h12345678;
        input_a_stb = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("bp_z",   output_z, 64'h400921FB60000000);
            chk("bp_stb", 64'(output_z_stb), 64'd1);
            chk("bp_ack", 64'(input_a_ack), 64'd0);
        end
        input_a_stb  = 1'b0;
        output_z_ack = 1'b1;
        @(posedge clk); #1;
        output_z_ack = 1'b0;
        chk("bp_xfer_stb", 64'(output_z_stb), 64'd0);
        chk("bp_xfer_ack", 64'(input_a_ack), 64'd0);
        chk("bp_keep_z", output_z, 64'h400921FB60000000);
        @(posedge clk); #1;
        chk("bp_ack_next", 64'(input_a_ack), 64'd1);

        // Output ack while idle must not disturb the next conversion.
        output_z_ack = 1'b1;
        @(posedge clk); #1;
        output_z_ack = 1'b0;
        send(32'h3F000000); get("half", 64'h3FE0000000000000, 1, 0);

        // Reset during NORMALISE discards the pending subnormal.
        send(32'h00000001);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_ack", 64'(input_a_ack), 64'd0);
        chk("midrst_stb", 64'(output_z_stb), 64'd0);
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (output_z_stb) seen = 1'b1;
        end
        chk("midrst_no_result", 64'(seen), 64'd0);
        send(32'h3F800000); get("after_rst", 64'h3FF0000000000000, 1, 0);

        // Random stream with random output ack gaps; about a third subnormal.
        for (int t = 0; t < 1000; t++) begin
            v = $urandom;
            if ($urandom_range(0, 2) == 0) v[30:23] = 8'h00;
            send(v);
            get("rand", ref_f2d(v), ref_lat(v), $urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #20000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/float_to_double.md
FLOAT_TO_DOUBLE -- requirements
Module: float_to_double

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset; all state changes occur on the rising edge of clk.
REQ-002 clk  input  1  system clock.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 input_a  input  32  IEEE-754 single-precision operand.
REQ-005 input_a_stb  input  1  upstream asserts when input_a is valid.
REQ-006 input_a_ack  output  1  registered; high only while the block is ready to accept an operand.
REQ-007 output_z  output  64  IEEE-754 double-precision result; registered.
REQ-008 output_z_stb  output  1  registered; high while output_z holds a valid result.
REQ-009 output_z_ack  input  1  downstream asserts when it accepts output_z.

Function
REQ-010 SHALL implement an FSM with states GET_A, CONVERT, NORMALISE and PUT_Z.
REQ-011 GET_A: input_a_ack SHALL be 1; on an edge with input_a_stb=1 and input_a_ack=1, SHALL latch input_a, drive input_a_ack to 0 and go to CONVERT.
REQ-012 input_a_ack SHALL be 0 in every state other than GET_A.
REQ-013 Field split: s=a[31], e=a[30:23], f=a[22:0]; z[63] SHALL be s in every case.
REQ-014 CONVERT, normal (e in 1..254): z[62:52]=e+896 (11-bit), z[51:0]={f,29'b0}; SHALL go to PUT_Z and set output_z_stb=1 on the same edge.
REQ-015 CONVERT, e=255 (Inf/NaN): z[62:52]=2047, z[51:0]={f,29'b0} (NaN payload and quiet bit preserved); SHALL go to PUT_Z as in REQ-014.
REQ-016 CONVERT, e=0 and f=0 (signed zero): z[62:0]=0; SHALL go to PUT_Z as in REQ-014.
REQ-017 CONVERT, e=0 and f!=0 (subnormal): SHALL load 24-bit mantissa m={1'b0,f} and signed exponent x=-126, then go to NORMALISE.
REQ-018 NORMALISE: if m[23]=0, SHALL shift m left by 1 and decrement x by 1, remaining in NORMALISE; one shift per cycle.
REQ-019 NORMALISE: if m[23]=1, SHALL set z[62:52]=x+1023 and z[51:0]={m[22:0],29'b0}, go to PUT_Z, and set output_z_stb=1 on the same edge.
REQ-020 Subnormal shift count k=23-p, where p is the bit index of the MSB set in f; k ranges from 1 to 23; the result is always a normal double and is never rounded.
REQ-021 Latency, with the accepting edge as E0: for normal, zero, Inf and NaN inputs, output_z_stb SHALL be 1 after edge E1; for subnormal inputs, after edge E(k+2).
REQ-022 PUT_Z: output_z and output_z_stb SHALL hold stable until an edge with output_z_stb=1 and output_z_ack=1; on that edge output_z_stb SHALL go to 0 and the state SHALL return to GET_A.
REQ-023 output_z_ack asserted outside PUT_Z SHALL be ignored; input_a_stb asserted outside GET_A SHALL be ignored and SHALL NOT overwrite the latched operand.
REQ-024 After a PUT_Z handshake, input_a_ack SHALL be 1 after the next edge; there SHALL be no back-to-back acceptance within the same edge as an output transfer.
REQ-025 output_z SHALL retain its last value after the transfer; only output_z_stb qualifies it.

Reset
REQ-026 When rst=1 at an edge, the block SHALL go to GET_A with output_z_stb=0 and input_a_ack=0, overriding any transition in that edge, including a reset during NORMALISE or PUT_Z.
REQ-027 input_a_ack SHALL rise after the first edge at which rst=0; the value of output_z after reset is don't-care.
REQ-028 A result pending at reset SHALL be discarded and SHALL NOT be re-presented.

Verification
REQ-029 input 0x3F800000 (1.0) with immediate output_z_ack -> output_z=0x3FF0000000000000, output_z_stb after E1.
REQ-030 input 0xC0200000 (-2.5) -> 0xC004000000000000; input 0x80000000 -> 0x8000000000000000; input 0x7F800000 -> 0x7FF0000000000000; input 0x7FC00000 -> 0x7FF8000000000000.
REQ-031 Subnormal inputs: 0x00000001 -> 0x36A0000000000000 with output_z_stb after E25 (k=23); 0x00400000 -> 0x3800000000000000 with output_z_stb after E3 (k=1).
REQ-032 Backpressure: hold output_z_ack=0 for 10 cycles in PUT_Z -> output_z and output_z_stb stable and input_a_ack=0 throughout; raise output_z_ack -> one transfer, then input_a_ack=1 on the following cycle.
REQ-033 Reset mid-operation: assert rst during NORMALISE for input 0x00000001 -> output_z_stb never rises for that operand; then input 0x3F800000 converts correctly.
REQ-034 Stream 1000 random singles from a file-reader source with random output_z_ack gaps -> every result matches the reference model's single-to-double conversion bit-exactly, in order, with none dropped or duplicated.
